// File: rtl/param_sp_ram_if.sv
// Access bus for param_sp_ram: request fields driven by the master and
// registered read data plus status returned by the RAM.
interface param_sp_ram_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                    en;
    logic                    we;
    logic [DATA_WIDTH/8-1:0] be;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   din;
    logic                    clr;
    logic [DATA_WIDTH-1:0]   dout;
    logic                    dout_valid;
    logic                    busy;

    modport master (
        output en, we, be, addr, din, clr,
        input  dout, dout_valid, busy
    );

    modport slave (
        input  en, we, be, addr, din, clr,
        output dout, dout_valid, busy
    );
endinterface

// File: rtl/param_sp_ram.sv
// Single-port RAM with byte enables, selectable write/read collision mode and
// a sequential clear sweep that also runs after every reset.
module param_sp_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int WRITE_MODE = 0
) (
    input  logic           clk,
    input  logic           rst,
    param_sp_ram_if.slave  bus
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                  state, state_n;
    logic [ADDR_WIDTH-1:0]   cnt, cnt_n;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   rd_word, wr_word;
    logic                    acc;

    assign rd_word  = mem[bus.addr];
    assign acc      = (state == IDLE) && bus.en;
    assign bus.busy = (state == CLEAR);

    // Byte-merged word: unselected bytes keep the stored contents.
    always_comb begin
        wr_word = rd_word;
        for (int i = 0; i < NB; i++) begin
            if (bus.be[i]) wr_word[8*i +: 8] = bus.din[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (state == CLEAR) begin
            cnt_n = cnt + 1'b1;
            if (&cnt) state_n = IDLE;
        end else if (bus.clr) begin
            state_n = CLEAR;
            cnt_n   = '0;
        end
    end

    // No reset on the array itself; the post-reset sweep zeroes it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR)
                mem[cnt] <= '0;
            else if (bus.en && bus.we)
                mem[bus.addr] <= wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.dout       <= '0;
            bus.dout_valid <= 1'b0;
        end else begin
            bus.dout_valid <= 1'b0;
            if (acc) begin
                if (!bus.we) begin
                    bus.dout       <= rd_word;
                    bus.dout_valid <= 1'b1;
                end else if (WRITE_MODE == 0) begin
                    bus.dout       <= rd_word;
                    bus.dout_valid <= 1'b1;
                end else if (WRITE_MODE == 1) begin
                    bus.dout       <= wr_word;
                    bus.dout_valid <= 1'b1;
                end
            end
        end
    end
endmodule
